// File: rtl/shift_pkg.sv
// Shared constants for the multi-cycle shift sequencer and its single-pass step.
package shift_pkg;

  // Largest shift a single pass can apply (matches the 3-bit step field)
  localparam int STEP_MAX_DEF = 7;

  // Shift mode encoding
  localparam logic [1:0] MODE_LSL = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  // Sequencer state encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

endpackage

// File: rtl/shift_step.sv
// Single combinational shift pass of 0..7 bits, reporting the last bit shifted out.
module shift_step
  import shift_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] i_work,
  input  logic [2:0]   i_step,
  input  logic [1:0]   i_mode,
  output logic [N-1:0] o_result,
  output logic         o_carry
);

  // Each shift is done one bit wider so the carry falls out in the guard bit.
  logic [N:0] w_left;
  logic [N:0] w_right;
  logic [N:0] w_arith;
  logic [N-1:0] w_rot;

  assign w_left  = {1'b0, i_work} << i_step;
  assign w_right = {i_work, 1'b0} >> i_step;
  assign w_arith = $signed({i_work, 1'b0}) >>> i_step;
  assign w_rot   = N'({i_work, i_work} >> i_step);

  // Select the pass result and carry for the requested mode
  always_comb begin
    o_result = i_work;
    o_carry  = 1'b0;
    case (i_mode)
      MODE_LSL: begin
        o_result = w_left[N-1:0];
        o_carry  = w_left[N];
      end
      MODE_LSR: begin
        o_result = w_right[N:1];
        o_carry  = w_right[0];
      end
      MODE_ASR: begin
        o_result = w_arith[N:1];
        o_carry  = w_arith[0];
      end
      default: begin
        // Rotation: the last bit out becomes the new MSB; a zero pass has no carry
        o_result = w_rot;
        o_carry  = (i_step != 3'd0) & w_rot[N-1];
      end
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: splits a full-range shift into passes of at most STEP_MAX bits.
//
//   state  | meaning
//   IDLE   | waiting for start; operands captured on accept
//   SHIFT  | one pass per clock, rem counts down to zero
//   FINISH | publish result/carry and pulse done on the next edge
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int N        = 32,
  parameter int AMT_W    = 5,
  parameter int STEP_MAX = STEP_MAX_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [N-1:0]     data_in,
  input  logic [AMT_W-1:0] amount,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  output logic [N-1:0]     data_out,
  output logic             carry_out
);

  logic [1:0]       r_state;
  logic [N-1:0]     r_work;
  logic [AMT_W-1:0] r_rem;
  logic [1:0]       r_mode;
  logic             r_carry;
  logic             r_done;
  logic [N-1:0]     r_data_out;
  logic             r_carry_out;

  logic [2:0]       w_step;
  logic [AMT_W-1:0] w_rem_next;
  logic [N-1:0]     w_shifted;
  logic             w_carry;

  // Pass size: whatever is left, capped at the step-field maximum
  always_comb begin
    if (r_rem > AMT_W'(STEP_MAX)) begin
      w_step = 3'(STEP_MAX);
    end else begin
      w_step = r_rem[2:0];
    end
  end

  assign w_rem_next = r_rem - AMT_W'(w_step);

  shift_step #(.N(N)) u_step (
    .i_work   (r_work),
    .i_step   (w_step),
    .i_mode   (r_mode),
    .o_result (w_shifted),
    .o_carry  (w_carry)
  );

  // Sequencer FSM plus the working and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_work      <= '0;
      r_rem       <= '0;
      r_mode      <= MODE_LSL;
      r_carry     <= 1'b0;
      r_done      <= 1'b0;
      r_data_out  <= '0;
      r_carry_out <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_work  <= data_in;
            r_rem   <= amount;
            r_mode  <= mode;
            r_carry <= 1'b0;
            r_state <= (amount != '0) ? ST_SHIFT : ST_FINISH;
          end
        end
        ST_SHIFT: begin
          r_work  <= w_shifted;
          r_carry <= w_carry;
          r_rem   <= w_rem_next;
          if (w_rem_next == '0) begin
            r_state <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          r_data_out  <= r_work;
          r_carry_out <= r_carry;
          r_done      <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign data_out  = r_data_out;
  assign carry_out = r_carry_out;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: directed table, random ops against a whole-shift model,
// and hand sequences for ignored start, back-to-back and mid-operation reset.
module tb_shift_sequencer;
  import shift_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] data_in;
  logic [4:0]  amount;
  logic [1:0]  mode;
  logic        busy;
  logic        done;
  logic [31:0] data_out;
  logic        carry_out;

  int n_checks = 0;
  int n_fail   = 0;

  shift_sequencer #(.N(32), .AMT_W(5), .STEP_MAX(7)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .data_in   (data_in),
    .amount    (amount),
    .mode      (mode),
    .busy      (busy),
    .done      (done),
    .data_out  (data_out),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  m;
    logic [31:0] d;
    logic [4:0]  amt;
    logic [31:0] exp_d;
    logic        exp_c;
    int          exp_lat;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Whole shift in one go; multi-pass decomposition must give the same answer.
  function automatic void model(input logic [1:0] m, input logic [31:0] d, input int amt,
                                output logic [31:0] r, output logic c);
    logic [63:0] wide;
    r = d;
    c = 1'b0;
    if (amt == 0) return;
    case (m)
      MODE_LSL: begin
        wide = {32'b0, d} << amt;
        r = wide[31:0];
        c = wide[32];
      end
      MODE_LSR: begin
        r = d >> amt;
        c = d[amt-1];
      end
      MODE_ASR: begin
        r = 32'($signed(d) >>> amt);
        c = d[amt-1];
      end
      default: begin
        wide = {d, d} >> amt;
        r = wide[31:0];
        c = r[31];
      end
    endcase
  endfunction

  // Called just after a negedge with the DUT idle (or showing done).
  // Cycle k after the accept edge is sampled at its negedge; returns in the done cycle.
  task automatic run_op(input logic [1:0] m, input logic [31:0] d, input logic [4:0] amt,
                        input int inj, output logic [31:0] r, output logic c,
                        output int lat, output int busy_cycles);
    data_in = d;
    amount  = amt;
    mode    = m;
    start   = 1'b1;
    @(posedge clk);
    lat = 0;
    busy_cycles = 0;
    r = '0;
    c = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (done) begin
        lat = k;
        r = data_out;
        c = carry_out;
        break;
      end
      if (k == 1) begin
        start   = 1'b0;
        data_in = $urandom;
        amount  = 5'($urandom);
        mode    = 2'($urandom);
      end
      if (inj != 0 && k == inj) begin
        start   = 1'b1;
        data_in = ~d;
        amount  = 5'd1;
        mode    = ~m;
      end
      if (inj != 0 && k == inj + 1) start = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic run_and_check(input string name, input logic [1:0] m, input logic [31:0] d,
                               input logic [4:0] amt, input int inj);
    logic [31:0] er, r;
    logic        ec, c;
    int          elat, lat, bc;
    model(m, d, int'(amt), er, ec);
    elat = (int'(amt) + 6) / 7 + 2;
    run_op(m, d, amt, inj, r, c, lat, bc);
    check({name, ".data"},    64'(r), 64'(er));
    check({name, ".carry"},   64'(c), 64'(ec));
    check({name, ".latency"}, 64'(lat), 64'(elat));
    check({name, ".busy"},    64'(bc), 64'(elat - 1));
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r;
    logic        c;
    int          lat, bc, pulses;

    vecs[0] = '{MODE_LSL, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 7};
    vecs[1] = '{MODE_LSR, 32'h8000_0000, 5'd8,  32'h0080_0000, 1'b0, 4};
    vecs[2] = '{MODE_ASR, 32'h8008_0000, 5'd20, 32'hFFFF_F800, 1'b1, 5};
    vecs[3] = '{MODE_ROR, 32'h0000_000F, 5'd4,  32'hF000_0000, 1'b1, 3};
    vecs[4] = '{MODE_ASR, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0, 2};
    vecs[5] = '{MODE_LSL, 32'h0200_0001, 5'd7,  32'h0000_0080, 1'b1, 3};

    reset   = 1'b1;
    start   = 1'b0;
    data_in = '0;
    amount  = '0;
    mode    = '0;
    repeat (3) @(negedge clk);
    check("reset.busy",      64'(busy), 64'(0));
    check("reset.done",      64'(done), 64'(0));
    check("reset.data_out",  64'(data_out), 64'(0));
    check("reset.carry_out", 64'(carry_out), 64'(0));
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_op(vecs[i].m, vecs[i].d, vecs[i].amt, 0, r, c, lat, bc);
      check($sformatf("vec%0d.data", i),    64'(r),   64'(vecs[i].exp_d));
      check($sformatf("vec%0d.carry", i),   64'(c),   64'(vecs[i].exp_c));
      check($sformatf("vec%0d.latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      check($sformatf("vec%0d.busy", i),    64'(bc),  64'(vecs[i].exp_lat - 1));
      @(negedge clk);
    end

    // Outputs hold between done pulses
    repeat (3) @(negedge clk);
    check("hold.data_out",  64'(data_out),  64'(32'h0000_0080));
    check("hold.carry_out", 64'(carry_out), 64'(1));

    // Random operations with gaps of 0..2 cycles (gap 0 is back-to-back)
    for (int i = 0; i < 60; i++) begin
      logic [4:0] a;
      a = 5'($urandom);
      if (i % 10 == 0) a = 5'd0;
      if (i % 10 == 1) a = 5'd31;
      if (i % 10 == 2) a = 5'd7;
      if (i % 10 == 3) a = 5'd14;
      run_and_check($sformatf("rnd%0d", i), 2'($urandom), $urandom, a, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // start during an operation is ignored
    @(negedge clk);
    run_and_check("midstart", MODE_LSR, 32'hA5A5_1234, 5'd31, 2);
    @(negedge clk);
    check("midstart.idle_after", 64'(busy), 64'(0));

    // Second start in the done cycle is accepted straight away
    run_and_check("b2b_first",  MODE_ROR, 32'h1234_5678, 5'd13, 0);
    check("b2b.idle_at_done", 64'(busy), 64'(0));
    run_and_check("b2b_second", MODE_ASR, 32'h8765_4321, 5'd9, 0);

    // Leave a nonzero result and carry, then reset in the middle of SHIFT
    run_and_check("pre_reset", MODE_ROR, 32'h0000_000F, 5'd4, 0);
    data_in = 32'hFFFF_FFFF;
    amount  = 5'd31;
    mode    = MODE_LSL;
    start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("midreset.busy_before", 64'(busy), 64'(1));
    reset = 1'b1;
    #1;
    check("midreset.busy",      64'(busy), 64'(0));
    check("midreset.done",      64'(done), 64'(0));
    check("midreset.data_out",  64'(data_out), 64'(0));
    check("midreset.carry_out", 64'(carry_out), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("midreset.no_done", 64'(pulses), 64'(0));
    run_and_check("post_reset", MODE_LSL, 32'h0000_0003, 5'd30, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
